// File: rtl/nap_countdown_timer.sv
// -----------------------------------------------------------------------------
// nap_countdown_timer
//
// A MM:SS countdown timer for a nap. The time is held as four BCD digits. It
// counts down once per second while running and raises an alarm at 00:00.
// The four digits are time-multiplexed onto one 4-bit digit code with a
// one-hot digit select, ready for a downstream 7-segment decoder. Code 4'hF
// means blank, and the decoder blanks any code above 9.
//
// Parameters
//   TICK_DIV  clk cycles per one-second tick (>= 2, even)
//   SCAN_DIV  clk cycles each digit slot is held on the display (>= 1)
//   DEF_MIN   preset minutes loaded at reset (1..99)
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   start_pause  in   one-cycle pulse: start / pause / resume / acknowledge alarm
//   clear        in   one-cycle pulse: back to IDLE and reload preset:00
//   min_inc      in   one-cycle pulse: preset minutes +1 (IDLE only, 99 -> 1)
//   bNum         out  digit code of the selected slot (4'hF = blank)
//   dig_sel      out  one-hot slot select: [0]=s1 [1]=s10 [2]=m1 [3]=m10
//   running      out  high while counting down
//   alarm        out  high once 00:00 is reached, until acknowledged
//
// Optional feature macro: NAP_ALARM_BLINK_EN
//   If this macro is defined, the display blinks while the alarm is active.
//   The blink phase toggles every TICK_DIV/2 cycles and starts high on entry
//   to DONE. While the phase is low, the display is dark.
// -----------------------------------------------------------------------------
module nap_countdown_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int DEF_MIN  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pause,
    input  logic       clear,
    input  logic       min_inc,
    output logic [3:0] bNum,
    output logic [3:0] dig_sel,
    output logic       running,
    output logic       alarm
);

    localparam int              TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              SW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]   SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [6:0]      PRESET_RST = 7'(DEF_MIN);
    localparam logic [7:0]      RST_BCD    = {4'(DEF_MIN / 10), 4'(DEF_MIN % 10)};
`ifdef NAP_ALARM_BLINK_EN
    localparam logic [TW-1:0]   HALF_LAST  = TW'(TICK_DIV / 2 - 1);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    // Binary minutes (0..99) to two BCD digits {tens, ones}.
    function automatic logic [7:0] preset_bcd(input logic [6:0] p);
        return {4'(p / 7'd10), 4'(p % 7'd10)};
    endfunction

    state_t        r_state;
    logic [6:0]    r_preset;
    logic [3:0]    r_m10, r_m1, r_s10, r_s1;
    logic [TW-1:0] r_presc;
    logic [SW-1:0] r_scan_cnt;
    logic [1:0]    r_scan_idx;
    logic [3:0]    r_bnum, r_dig_sel;
    logic          r_running, r_alarm;
`ifdef NAP_ALARM_BLINK_EN
    logic          r_blink;
    logic          w_blink_next;
`endif

    state_t        w_state_next;
    logic [6:0]    w_preset_next, w_preset_inc;
    logic [3:0]    w_m10_next, w_m1_next, w_s10_next, w_s1_next;
    logic [TW-1:0] w_presc_next, w_presc_inc;
    logic          w_tick;
    logic [7:0]    w_reload, w_reload_inc;
    logic [3:0]    w_dec_m10, w_dec_m1, w_dec_s10, w_dec_s1;
    logic          w_borrow_s1, w_borrow_s10, w_borrow_m1, w_at_one;
    logic          w_scan_wrap;
    logic [SW-1:0] w_scan_cnt_next;
    logic [1:0]    w_scan_idx_next;
    logic [3:0]    w_sel_onehot;
    logic [3:0]    w_digit_next [4];
    logic [3:0]    w_bnum_next, w_dig_sel_next;

    // Prescaler and preset helpers
    assign w_tick       = (r_presc == TICK_LAST);
    assign w_presc_inc  = w_tick ? '0 : r_presc + TW'(1);
    assign w_preset_inc = (r_preset >= 7'd99) ? 7'd1 : r_preset + 7'd1;
    assign w_reload     = preset_bcd(r_preset);
    assign w_reload_inc = preset_bcd(w_preset_inc);

    // One-second decrement. Each digit borrows from the next digit up.
    assign w_borrow_s1  = (r_s1 == 4'd0);
    assign w_borrow_s10 = w_borrow_s1 && (r_s10 == 4'd0);
    assign w_borrow_m1  = w_borrow_s10 && (r_m1 == 4'd0);
    assign w_dec_s1     = w_borrow_s1 ? 4'd9 : r_s1 - 4'd1;
    assign w_dec_s10    = w_borrow_s1 ? (w_borrow_s10 ? 4'd5 : r_s10 - 4'd1) : r_s10;
    assign w_dec_m1     = w_borrow_s10 ? (w_borrow_m1 ? 4'd9 : r_m1 - 4'd1) : r_m1;
    assign w_dec_m10    = w_borrow_m1 ? r_m10 - 4'd1 : r_m10;
    // When the current value is 00:01, this tick lands on 00:00.
    assign w_at_one     = (r_m10 == 4'd0) && (r_m1 == 4'd0) && (r_s10 == 4'd0) && (r_s1 == 4'd1);

    // Scan counter free-runs in every state.
    assign w_scan_wrap     = (r_scan_cnt == SCAN_LAST);
    assign w_scan_cnt_next = w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
    assign w_scan_idx_next = w_scan_wrap ? r_scan_idx + 2'd1 : r_scan_idx;

    always_comb begin
        w_state_next  = r_state;
        w_preset_next = r_preset;
        w_m10_next    = r_m10;
        w_m1_next     = r_m1;
        w_s10_next    = r_s10;
        w_s1_next     = r_s1;
        w_presc_next  = r_presc;
`ifdef NAP_ALARM_BLINK_EN
        w_blink_next  = r_blink;
`endif
        if (clear) begin
            w_state_next             = ST_IDLE;
            {w_m10_next, w_m1_next}  = w_reload;
            w_s10_next               = 4'd0;
            w_s1_next                = 4'd0;
            w_presc_next             = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_pause) begin
                        w_state_next = ST_RUN;
                        w_presc_next = '0;
                    end else if (min_inc) begin
                        w_preset_next            = w_preset_inc;
                        {w_m10_next, w_m1_next}  = w_reload_inc;
                        w_s10_next               = 4'd0;
                        w_s1_next                = 4'd0;
                    end
                end
                ST_RUN: begin
                    w_presc_next = w_presc_inc;
                    if (w_tick) begin
                        w_m10_next = w_dec_m10;
                        w_m1_next  = w_dec_m1;
                        w_s10_next = w_dec_s10;
                        w_s1_next  = w_dec_s1;
                    end
                    // If a tick reaches zero, DONE takes priority over a pause
                    // in the same cycle.
                    if (w_tick && w_at_one) begin
                        w_state_next = ST_DONE;
`ifdef NAP_ALARM_BLINK_EN
                        w_blink_next = 1'b1;
`endif
                    end else if (start_pause) begin
                        w_state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_pause) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // The prescaler keeps running here and sets the blink rate.
                    w_presc_next = w_presc_inc;
`ifdef NAP_ALARM_BLINK_EN
                    if ((r_presc == HALF_LAST) || w_tick) begin
                        w_blink_next = ~r_blink;
                    end
`endif
                    if (start_pause) begin
                        w_state_next             = ST_IDLE;
                        {w_m10_next, w_m1_next}  = w_reload;
                        w_s10_next               = 4'd0;
                        w_s1_next                = 4'd0;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Display mux works on next-cycle values, so the registered bNum and
    // dig_sel always show the same slot.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign w_sel_onehot[gi] = (w_scan_idx_next == 2'(gi));
        end
    endgenerate

    assign w_digit_next[0] = w_s1_next;
    assign w_digit_next[1] = w_s10_next;
    assign w_digit_next[2] = w_m1_next;
    assign w_digit_next[3] = (w_m10_next == 4'd0) ? 4'hF : w_m10_next;

    always_comb begin
        w_dig_sel_next = w_sel_onehot;
        w_bnum_next    = w_digit_next[w_scan_idx_next];
`ifdef NAP_ALARM_BLINK_EN
        if ((w_state_next == ST_DONE) && !w_blink_next) begin
            w_dig_sel_next = 4'b0000;
            w_bnum_next    = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_preset   <= PRESET_RST;
            r_m10      <= RST_BCD[7:4];
            r_m1       <= RST_BCD[3:0];
            r_s10      <= 4'd0;
            r_s1       <= 4'd0;
            r_presc    <= '0;
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
            r_dig_sel  <= 4'b0001;
            r_bnum     <= 4'd0;
            r_running  <= 1'b0;
            r_alarm    <= 1'b0;
`ifdef NAP_ALARM_BLINK_EN
            r_blink    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_preset   <= w_preset_next;
            r_m10      <= w_m10_next;
            r_m1       <= w_m1_next;
            r_s10      <= w_s10_next;
            r_s1       <= w_s1_next;
            r_presc    <= w_presc_next;
            r_scan_cnt <= w_scan_cnt_next;
            r_scan_idx <= w_scan_idx_next;
            r_dig_sel  <= w_dig_sel_next;
            r_bnum     <= w_bnum_next;
            r_running  <= (w_state_next == ST_RUN);
            r_alarm    <= (w_state_next == ST_DONE);
`ifdef NAP_ALARM_BLINK_EN
            r_blink    <= w_blink_next;
`endif
        end
    end

    assign bNum    = r_bnum;
    assign dig_sel = r_dig_sel;
    assign running = r_running;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_nap_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_nap_countdown_timer
//
// Directed bench for nap_countdown_timer with TICK_DIV=4, SCAN_DIV=2 and
// DEF_MIN=1. The reference model keeps the time as a total number of seconds
// plus a cycle count within the current second. The expected display is
// derived from these values with plain arithmetic. One process compares all
// outputs on every cycle. Hand-computed literals pin both the DUT and the model
// at key points.
// -----------------------------------------------------------------------------
module tb_nap_countdown_timer;

    localparam int TICK = 4;
    localparam int SCAN = 2;
    localparam int DEFM = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_pause = 1'b0;
    logic       clear = 1'b0;
    logic       min_inc = 1'b0;
    logic [3:0] bNum;
    logic [3:0] dig_sel;
    logic       running;
    logic       alarm;

    nap_countdown_timer #(
        .TICK_DIV (TICK),
        .SCAN_DIV (SCAN),
        .DEF_MIN  (DEFM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_pause (start_pause),
        .clear       (clear),
        .min_inc     (min_inc),
        .bNum        (bNum),
        .dig_sel     (dig_sel),
        .running     (running),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0=IDLE 1=RUN 2=PAUSE 3=DONE
    bit m_valid = 1'b0;
    int m_mode, m_secs, m_frac, m_preset, m_scan, m_done_cyc;
    int e_sel, e_bnum, e_min, e_sec, e_idx;
    int e_dg [4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        if (rst) begin
            m_valid = 1'b1; m_mode = 0; m_preset = DEFM; m_secs = DEFM * 60;
            m_frac = 0; m_scan = 0; m_done_cyc = 0;
            return;
        end
        if (!m_valid) return;
        m_scan = (m_scan + 1) % (4 * SCAN);
        if (clear) begin
            m_mode = 0; m_secs = m_preset * 60; m_frac = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (start_pause) begin
                        m_mode = 1; m_frac = 0;
                    end else if (min_inc) begin
                        m_preset = m_preset % 99 + 1;
                        m_secs = m_preset * 60;
                    end
                end
                1: begin
                    m_frac++;
                    if (m_frac == TICK) begin
                        m_frac = 0;
                        m_secs--;
                    end
                    if (m_secs == 0) begin
                        m_mode = 3; m_done_cyc = 0;
                    end else if (start_pause) begin
                        m_mode = 2;
                    end
                end
                2: if (start_pause) m_mode = 1;
                default: begin
                    m_done_cyc++;
                    if (start_pause) begin
                        m_mode = 0; m_secs = m_preset * 60;
                    end
                end
            endcase
        end
    endtask

    // Per-cycle compare. The model updates with the inputs used at the last
    // rising edge, and the outputs are then sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            if (m_valid) begin
                e_min   = m_secs / 60;
                e_sec   = m_secs % 60;
                e_dg[0] = e_sec % 10;
                e_dg[1] = e_sec / 10;
                e_dg[2] = e_min % 10;
                e_dg[3] = (e_min / 10 == 0) ? 15 : e_min / 10;
                e_idx   = m_scan / SCAN;
                e_sel   = 1 << e_idx;
                e_bnum  = e_dg[e_idx];
`ifdef NAP_ALARM_BLINK_EN
                if (m_mode == 3 && ((m_done_cyc / (TICK / 2)) % 2) == 1) begin
                    e_sel  = 0;
                    e_bnum = 15;
                end
`endif
                chk("cmp_dig_sel", int'(dig_sel), e_sel);
                chk("cmp_bNum", int'(bNum), e_bnum);
                chk("cmp_running", int'(running), (m_mode == 1) ? 1 : 0);
                chk("cmp_alarm", int'(alarm), (m_mode == 3) ? 1 : 0);
            end
        end
    end

    // One input cycle: drive after a falling edge and return just after the
    // next falling edge, once the rising edge between them has used the inputs.
    task automatic cyc(input logic r, input logic c, input logic s, input logic i);
        rst = r; clear = c; start_pause = s; min_inc = i;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sel(input logic [3:0] tgt);
        int k;
        k = 0;
        while (dig_sel != tgt && k < 8) begin
            cyc(0, 0, 0, 0);
            k++;
        end
        chk("wait_sel", int'(dig_sel), int'(tgt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zeros;
        // Reset scan
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_dig_sel", int'(dig_sel), 1);
        chk("rst_bNum", int'(bNum), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("model_rst_secs", m_secs, 60);
        cyc(0, 0, 0, 0);
        chk("scan_c1_sel", int'(dig_sel), 1);
        cyc(0, 0, 0, 0);
        chk("scan_c2_sel", int'(dig_sel), 2);
        chk("scan_c2_bNum", int'(bNum), 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("scan_c4_sel", int'(dig_sel), 4);
        chk("scan_c4_bNum", int'(bNum), 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("scan_c6_sel", int'(dig_sel), 8);
        chk("scan_c6_bNum", int'(bNum), 15);

        // Full countdown from 01:00
        cyc(0, 0, 1, 0);
        chk("start_running", int'(running), 1);
        repeat (3) cyc(0, 0, 0, 0);
        chk("model_pre_tick", m_secs, 60);
        cyc(0, 0, 0, 0);
        chk("model_first_dec", m_secs, 59);
        repeat (235) cyc(0, 0, 0, 0);
        chk("pre_final_running", int'(running), 1);
        chk("pre_final_alarm", int'(alarm), 0);
        cyc(0, 0, 0, 0);
        chk("final_alarm", int'(alarm), 1);
        chk("final_running", int'(running), 0);
        chk("model_final_secs", m_secs, 0);
        zeros = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 0);
            if (dig_sel == 4'b0000) zeros++;
        end
`ifdef NAP_ALARM_BLINK_EN
        chk("done_dark_cycles", zeros, 4);
`else
        chk("done_dark_cycles", zeros, 0);
`endif
        cyc(0, 0, 1, 0);
        chk("done_ack_alarm", int'(alarm), 0);
        chk("model_done_ack_secs", m_secs, 60);

        // Pause / resume
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("pause_running", int'(running), 0);
        repeat (10) cyc(0, 0, 0, 0);
        chk("model_paused_secs", m_secs, 60);
        cyc(0, 0, 1, 0);
        chk("resume_running", int'(running), 1);
        cyc(0, 0, 0, 0);
        chk("model_resume_r1", m_secs, 60);
        cyc(0, 0, 0, 0);
        chk("model_resume_r2", m_secs, 59);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("model_tick_pause_secs", m_secs, 58);
        chk("tick_pause_running", int'(running), 0);

        // Priority: clear beats start_pause at 00:37
        cyc(0, 0, 1, 0);
        repeat (84) cyc(0, 0, 0, 0);
        chk("model_at_37", m_secs, 37);
        chk("run_at_37", int'(running), 1);
        cyc(0, 1, 1, 0);
        chk("clear_running", int'(running), 0);
        chk("model_clear_secs", m_secs, 60);
        chk("model_clear_mode", m_mode, 0);

        // Preset wrap
        repeat (98) cyc(0, 0, 0, 1);
        chk("model_preset_99", m_preset, 99);
        wait_sel(4'b1000);
        chk("preset99_m10", int'(bNum), 9);
        wait_sel(4'b0100);
        chk("preset99_m1", int'(bNum), 9);
        cyc(0, 0, 0, 1);
        chk("model_preset_wrap", m_preset, 1);
        wait_sel(4'b0100);
        chk("wrap_m1", int'(bNum), 1);
        wait_sel(4'b1000);
        chk("wrap_m10_blank", int'(bNum), 15);

        // min_inc ignored while running
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1);
        chk("model_run_inc_preset", m_preset, 1);
        cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nap_countdown_timer.md
# nap_countdown_timer

Countdown timer for a nap: holds a MM:SS value as four BCD digits, decrements once per second while running, and raises an alarm at 00:00. It sits directly upstream of the 7-segment decoder stage. It time-multiplexes the four digits onto one 4-bit digit code (`bNum`) plus a one-hot digit select. The code value 4'hF means blank; the decoder drives all segments off for any code above 9.

## Interface
- `TICK_DIV`, 50_000_000 — clk cycles per one-second tick (≥2, even).
- `SCAN_DIV`, 50_000 — clk cycles per display scan step (≥1).
- `DEF_MIN`, 20 — preset minutes loaded at reset (1–99).
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `start_pause`  in  1  — one-cycle pulse, already debounced.
- `clear`  in  1  — one-cycle pulse.
- `min_inc`  in  1  — one-cycle pulse; increments preset minutes (IDLE only).
- `bNum`  out  4  — digit code for the currently selected digit; 4'hF = blank.
- `dig_sel`  out  4  — one-hot, active-high. [0]=sec ones, [1]=sec tens, [2]=min ones, [3]=min tens.
- `running`  out  1  — high in RUN.
- `alarm`  out  1  — high in DONE.

## Operation
- **State:** 2-bit FSM with states IDLE, RUN, PAUSE, DONE.
- **Registers:** preset (7-bit binary, 1–99); time digits m10, m1, s10, s1 (BCD, s10 ≤ 5).
- **Reset:**
  - FSM = IDLE, preset = DEF_MIN, time = DEF_MIN:00.
  - Prescaler = 0, scan index = 0, scan counter = 0.
  - Outputs: `dig_sel`=0001, `bNum`=0, `running`=0, `alarm`=0.
- **Input priority in one cycle:** `clear` > `start_pause` > `min_inc`.
- **`clear`:** from any state → IDLE; time reloaded to preset:00; prescaler = 0.
- **IDLE:**
  - `start_pause` → RUN, prescaler cleared.
  - `min_inc`: preset +1, wrapping 99→1; time reloaded to the new preset:00.
- **RUN:**
  - Prescaler counts 0..TICK_DIV−1. On wrap, decrement time:
    - s1 0→9 with borrow; s10 0→5 with borrow; m1 0→9 with borrow; m10 −1.
  - If the decrement result is 00:00 → DONE.
  - `start_pause` → PAUSE. If a tick wrap lands in the same cycle, the decrement is applied first.
- **PAUSE:**
  - Prescaler and time hold; the fractional second is preserved.
  - `start_pause` → RUN, continuing from the held prescaler value.
  - `min_inc` is ignored.
- **DONE:**
  - Time holds 00:00.
  - `start_pause` → IDLE with time reloaded to preset:00.
  - Prescaler free-runs (used for blink).
- **Scan:**
  - Scan counter free-runs in all states. On wrap at SCAN_DIV−1, scan index advances 0→1→2→3→0.
  - Leading-zero blank: when m10 = 0, its slot shows 4'hF.
- **Output registers:** `bNum` and `dig_sel` are registered together from the scan index and the time digits; they never disagree in any cycle. `running` and `alarm` are registered decodes of the next state.

## Timing
- `start_pause` at cycle N → `running`=1 at N+1.
- First decrement at cycle N+TICK_DIV.
- Decrement from 00:01 → `alarm`=1 and `running`=0 one cycle after the final tick edge.
- Time-digit change → visible on `bNum` no later than the next cycle on which that digit is selected.
- Each digit slot is held for SCAN_DIV cycles.
- `rst` asserted mid-count overrides all inputs that cycle; reset values appear the following cycle.

## Configuration
- `NAP_ALARM_BLINK_EN` defined:
  - In DONE, a blink phase bit toggles every TICK_DIV/2 cycles, starting high on entry to DONE.
  - While the phase is low, `dig_sel`=0000 and `bNum`=4'hF.
- Undefined: DONE shows a steady scanned 00:00 (m10 slot blank).
- `alarm` behaves identically in both builds.

## Test plan
All scenarios use TICK_DIV=4, SCAN_DIV=2, DEF_MIN=1.
- **Reset scan:** pulse `rst`. → `dig_sel` cycles 0001, 0010, 0100, 1000, each held 2 cycles. `bNum` sequence is 0, 0, 1, F. `running`=0, `alarm`=0.
- **Full countdown:** `start_pause` pulse. → `running`=1 next cycle. Time 00:59 after 4 cycles; 00:00 after 240 cycles. `alarm`=1 and `running`=0 the cycle after that tick.
- **Pause/resume:**
  - Pause 2 cycles after start; resume after 10 idle cycles. → No decrement while paused.
  - First decrement lands exactly 2 cycles after resume.
  - Same-cycle tick + pause → decrement applied, then PAUSE.
- **Preset wrap:** 98 `min_inc` pulses in IDLE → displayed time 99:00. One more → 01:00. `min_inc` during RUN → no change.
- **Priority:** `clear` and `start_pause` in the same cycle during RUN at 00:37 → IDLE, time 01:00, `running`=0. `start_pause` in DONE → IDLE, time 01:00.
- **Blink:**
  - With `NAP_ALARM_BLINK_EN`, in DONE: `dig_sel` scans for 2 cycles, then is 0000 for 2 cycles, repeating.
  - Without the macro: uninterrupted scan of 0, 0, 0, F.
